// File: rtl/fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue_if : fetch-side / decode-side handshake of the queue  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  logic                     flush;
  logic                     in_valid;
  logic [XLEN-1:0]          in_pc;
  logic [XLEN-1:0]          in_inst;
  logic                     in_ready;
  logic                     out_valid;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_inst;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry pc/instruction FIFO between fetch and   |
// | decode with flush; FETCHQ_BYPASS_EN enables empty-queue bypass.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wire logic      clk,
  input  wire logic      nrst,
  fetch_queue_if.slave   fq
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one = 1;
  localparam logic [c_aw-1:0] c_ptr_one = 1;

  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [XLEN-1:0] r_mem_inst [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);

`ifdef FETCHQ_BYPASS_EN
  // Empty queue forwards the offered entry straight to decode.
  assign w_bypass     = nrst && w_empty && fq.in_valid && !fq.flush;
  assign fq.out_valid = !w_empty || w_bypass;
  assign fq.out_pc    = w_bypass ? fq.in_pc   : (w_empty ? '0 : r_mem_pc[r_rd_ptr]);
  assign fq.out_inst  = w_bypass ? fq.in_inst : (w_empty ? '0 : r_mem_inst[r_rd_ptr]);
`else
  assign w_bypass     = 1'b0;
  assign fq.out_valid = !w_empty;
  assign fq.out_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign fq.out_inst  = w_empty ? '0 : r_mem_inst[r_rd_ptr];
`endif

  // A bypassed entry consumed in the same cycle is never stored.
  assign w_push = fq.in_valid && !w_full && !fq.flush && !(w_bypass && fq.out_ready);
  assign w_pop  = !w_empty && fq.out_ready && !fq.flush;

  assign fq.in_ready = !w_full;
  assign fq.count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= fq.in_pc;
      r_mem_inst[r_wr_ptr] <= fq.in_inst;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (fq.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire
